// File: rtl/mult_pkg.sv
// Definitions shared by the multiplier and its BCD-to-binary decoder:
// the decoder state type, the digit-count helper and the largest legal BCD nibble.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} b2b_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int bcd_digits(input int n);
        return ((n * 2) / 3) + 1;
    endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One decimal accumulation step: acc*10 + digit.
// Also reports whether the incoming nibble is a legal BCD digit.
module bcd_digit_mac
    import mult_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             digit_ok_o
);

    // acc*10 is built from shifts so no multiplier is inferred
    assign acc_o      = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);
    assign digit_ok_o = (digit_i <= BCD_MAX);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary decoder: one digit per clock, most-significant digit first,
// with saturation on overflow and an error flag for non-decimal nibbles.
module bcd_to_bin_seq
    import mult_pkg::*;
#(
    parameter  int N      = 8,
    localparam int DIGITS = bcd_digits(N),
    localparam int BCD_W  = DIGITS * 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd,
    output logic [2*N-1:0]   out,
    output logic             finish,
    output logic             busy,
    output logic             ovf,
    output logic             err
);

    localparam int ACC_W = 2 * N + 4;
    localparam int CNT_W = $clog2(DIGITS + 1);

    b2b_state_t       state_q, state_d;
    logic [BCD_W-1:0] shift_q, shift_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic             err_flag_q, err_flag_d;
    logic [2*N-1:0]   out_q, out_d;
    logic             finish_q, finish_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [ACC_W-1:0] mac_acc;
    logic             mac_digit_ok;
    logic             step_ovf;

    bcd_digit_mac #(
        .ACC_W(ACC_W)
    ) u_mac (
        .acc_i     (acc_q),
        .digit_i   (shift_q[BCD_W-1 -: 4]),
        .acc_o     (mac_acc),
        .digit_ok_o(mac_digit_ok)
    );

    assign step_ovf = |mac_acc[ACC_W-1:2*N];

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_flag_d = ovf_flag_q;
        err_flag_d = err_flag_q;
        out_d      = out_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        finish_d   = 1'b0;

        case (state_q)
            CONV: begin
                acc_d      = mac_acc;
                shift_d    = shift_q << 4;
                cnt_d      = cnt_q + CNT_W'(1);
                ovf_flag_d = ovf_flag_q | step_ovf;
                err_flag_d = err_flag_q | ~mac_digit_ok;
                if (cnt_q == CNT_W'(DIGITS - 1)) begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                    // A bad digit makes the value meaningless, so it outranks overflow
                    if (err_flag_d) begin
                        out_d = '0;
                        ovf_d = 1'b0;
                        err_d = 1'b1;
                    end else if (ovf_flag_d) begin
                        out_d = '1;
                        ovf_d = 1'b1;
                        err_d = 1'b0;
                    end else begin
                        out_d = mac_acc[2*N-1:0];
                        ovf_d = 1'b0;
                        err_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d    = CONV;
                    shift_d    = bcd;
                    acc_d      = '0;
                    cnt_d      = '0;
                    ovf_flag_d = 1'b0;
                    err_flag_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            err_flag_q <= 1'b0;
            out_q      <= '0;
            finish_q   <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_flag_q <= ovf_flag_d;
            err_flag_q <= err_flag_d;
            out_q      <= out_d;
            finish_q   <= finish_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    assign out    = out_q;
    assign finish = finish_q;
    assign ovf    = ovf_q;
    assign err    = err_q;
    assign busy   = (state_q == CONV);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: expected results come from a plain
// decimal-arithmetic model and are checked by a monitor on every finish pulse.
module tb_bcd_to_bin_seq;

    localparam int N      = 8;
    localparam int DIGITS = 6;
    localparam int BCD_W  = 24;

    typedef struct {
        logic [2*N-1:0] out;
        logic           ovf;
        logic           err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [BCD_W-1:0] bcd = '0;
    logic [2*N-1:0]   out;
    logic             finish;
    logic             busy;
    logic             ovf;
    logic             err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   finish_count = 0;
    int   cyc = 0;
    int   finish_cyc = 0;
    int   start_cyc = 0;

    bcd_to_bin_seq #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bcd   (bcd),
        .out   (out),
        .finish(finish),
        .busy  (busy),
        .ovf   (ovf),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Decode the word as a decimal number; err dominates, then saturation
    function automatic exp_t ref_model(input logic [BCD_W-1:0] w);
        exp_t    e;
        longint  v;
        bit      bad;
        int      d;
        v   = 0;
        bad = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(w[i*4 +: 4]);
            if (d > 9) bad = 1;
            v = v * 10 + d;
        end
        if (bad) begin
            e.out = '0; e.ovf = 1'b0; e.err = 1'b1;
        end else if (v > 65535) begin
            e.out = '1; e.ovf = 1'b1; e.err = 1'b0;
        end else begin
            e.out = 16'(v); e.ovf = 1'b0; e.err = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [BCD_W-1:0] to_bcd(input int value);
        logic [BCD_W-1:0] w;
        int               v;
        v = value;
        w = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return w;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && finish) begin
            finish_count++;
            finish_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_finish actual=1 expected=0 out=%0h at t=%0t", out, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("out", 32'(out), 32'(e.out));
                check_output("ovf", 32'(ovf), 32'(e.ovf));
                check_output("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic apply_stimulus(input logic [BCD_W-1:0] v);
        bcd   = v;
        start = 1'b1;
        sb.push_back(ref_model(v));
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        check_output("busy_in_conv", 32'(busy), 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL finish_timeout pending=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_out"},    32'(out),    32'd0);
        check_output({tag, "_finish"}, 32'(finish), 32'd0);
        check_output({tag, "_busy"},   32'(busy),   32'd0);
        check_output({tag, "_ovf"},    32'(ovf),    32'd0);
        check_output({tag, "_err"},    32'(err),    32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fc;
        int a;
        int b;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic conversion and its latency
        apply_stimulus(24'h065025);
        wait_drain();
        check_output("latency", 32'(finish_cyc - start_cyc), 32'd6);

        // Range boundaries and saturation
        apply_stimulus(24'h065535);
        wait_drain();
        apply_stimulus(24'h065536);
        wait_drain();
        apply_stimulus(24'h999999);
        wait_drain();

        // Illegal digit, then recovery
        apply_stimulus(24'h00001A);
        wait_drain();
        apply_stimulus(24'h000123);
        wait_drain();

        // start held through CONV is ignored; restart from the DONE cycle
        fc    = finish_count;
        bcd   = 24'h000777;
        start = 1'b1;
        sb.push_back(ref_model(24'h000777));
        @(posedge clk);
        #1;
        for (int i = 0; i < DIGITS; i++) begin
            bcd = BCD_W'($urandom);
            @(posedge clk);
            #1;
        end
        bcd = 24'h000042;
        sb.push_back(ref_model(24'h000042));
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        repeat (DIGITS + 3) @(posedge clk);
        #1;
        check_output("held_start_finishes", 32'(finish_count - fc), 32'd2);

        // Reset in the middle of a conversion
        bcd   = 24'h012345;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        fc    = finish_count;
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (DIGITS + 4) @(posedge clk);
        #1;
        check_output("no_finish_after_reset", 32'(finish_count - fc), 32'd0);
        apply_stimulus(24'h012345);
        wait_drain();

        // Loopback: products of 8-bit operands in decimal form
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(255, 0));
            b = int'($urandom_range(255, 0));
            apply_stimulus(to_bcd(a * b));
            wait_drain();
        end

        // Arbitrary nibble patterns exercise err and ovf
        for (int i = 0; i < 60; i++) begin
            apply_stimulus(BCD_W'($urandom));
            wait_drain();
        end

        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
